exec_stage_md: RTL and testbench

Parametrised pipeline execute stage: WIDTH-bit ALU with an N-source forwarding network, RegDst/ALUSrc muxing, and an iterative multiply/divide unit with HI/LO registers. Sits between the ID/EX and EX/MEM pipeline registers. Raises a stall request toward the hazard unit while a multi-cycle operation is in flight.

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_md_unit.sv | 156 +++++++++++++++
 rtl/exec_stage_md.sv | 90 +++++++++
 tb/tb_exec_stage_md.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, multiply/divide FSM states,
// and the helper that classifies multi-cycle ops.
package exec_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpSlt   = 4'd6,
    OpSltu  = 4'd7,
    OpMult  = 4'd8,
    OpMultu = 4'd9,
    OpDiv   = 4'd10,
    OpDivu  = 4'd11,
    OpMfhi  = 4'd12,
    OpMflo  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdBusy = 2'd1,
    MdDone = 2'd2
  } md_state_e;

  function automatic logic is_md_op(alu_op_e op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/exec_md_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers and its IDLE/BUSY/DONE FSM.
// Divider datapath is present only when EXEC_DIV_EN is defined.
module exec_md_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_flush,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_mcand;
  logic             r_is_div, r_neg_q, r_neg_r;

  logic             w_is_mul, w_signed, w_start, w_busy, w_last;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo, w_step_hi, w_step_lo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_mul = (i_op == OpMult) || (i_op == OpMultu);
  assign w_signed = (i_op == OpMult) || (i_op == OpDiv);

`ifdef EXEC_DIV_EN
  assign w_start = (r_state == MdIdle) && i_valid && is_md_op(i_op) && !i_flush;
`else
  assign w_start = (r_state == MdIdle) && i_valid && w_is_mul && !i_flush;
`endif

  assign w_busy  = (r_state == MdBusy);
  assign w_last  = w_busy && (r_count == CW'(1));
  assign o_done  = w_last && !i_flush;
  assign o_stall = rst_n && (w_start || w_busy);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      MdIdle: begin
        if (w_start) begin
          w_state_nxt = MdBusy;
          w_count_nxt = CW'(WIDTH);
        end
      end
      MdBusy: begin
        if (i_flush) begin
          w_state_nxt = MdIdle;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count - CW'(1);
          if (w_last) w_state_nxt = MdDone;
        end
      end
      MdDone:  w_state_nxt = MdIdle;
      default: w_state_nxt = MdIdle;
    endcase
  end

  // Iterate on magnitudes; signs are reapplied when the result is written.
  assign w_a_neg = w_signed && i_a[WIDTH-1];
  assign w_b_neg = w_signed && i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Shift-add: low half holds the multiplier, product bits shift in from the top.
  assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

`ifdef EXEC_DIV_EN
  logic [WIDTH:0] w_shift;
  logic           w_ge;

  // Restoring divide: high half is the partial remainder, low half dividend -> quotient.
  assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_mcand});
  assign w_div_hi = w_ge ? (w_shift[WIDTH-1:0] - r_mcand) : w_shift[WIDTH-1:0];
  assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};
`else
  assign w_div_hi = '0;
  assign w_div_lo = '0;
`endif

  assign w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo = r_is_div ? w_div_lo : w_mul_lo;
  assign w_prod    = {w_mul_hi, w_mul_lo};

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_is_div) begin
      // Zero divisor leaves |A| in the remainder, so the sign fix-up restores the dividend.
      w_res_lo = (r_mcand == '0) ? '1 : (r_neg_q ? -w_div_lo : w_div_lo);
      w_res_hi = r_neg_r ? -w_div_hi : w_div_hi;
    end else begin
      {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MdIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_start) begin
        r_acc_hi <= '0;
        r_acc_lo <= w_a_mag;
        r_mcand  <= w_b_mag;
        r_is_div <= !w_is_mul;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
      end else if (w_busy) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
      end
      if (o_done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

endmodule

// File: rtl/exec_stage_md.sv
// Pipeline execute stage: forwarding network, ALU, RegDst/ALUSrc muxes and the
// multi-cycle multiply/divide unit. Divide support is enabled with EXEC_DIV_EN.
module exec_stage_md
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned FWD_SRCS = 2,
  localparam int unsigned FSW     = $clog2(FWD_SRCS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_e,
  input  logic                      flush_e,
  input  logic [3:0]                alu_ctrl_e,
  input  logic                      alu_src_e,
  input  logic                      reg_dst_e,
  input  logic [WIDTH-1:0]          reg1,
  input  logic [WIDTH-1:0]          reg2,
  input  logic [WIDTH-1:0]          sign_imm_e,
  input  logic [REG_AW-1:0]         rs_e,
  input  logic [REG_AW-1:0]         rt_e,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic [FSW-1:0]            fwd_a_e,
  input  logic [FSW-1:0]            fwd_b_e,
  input  logic [FWD_SRCS*WIDTH-1:0] fwd_vals,
  output logic [WIDTH-1:0]          alu_out_e,
  output logic [WIDTH-1:0]          write_data_e,
  output logic [REG_AW-1:0]         write_reg_e,
  output logic [REG_AW-1:0]         rs_hazard,
  output logic [REG_AW-1:0]         rt_hazard,
  output logic                      md_stall,
  output logic                      md_done
);

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_src_a, w_src_b, w_op_b, w_hi, w_lo;

  assign w_op = alu_op_e'(alu_ctrl_e);

  // Out-of-range selects fall through to the register operand.
  always_comb begin
    w_src_a = reg1;
    w_src_b = reg2;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (fwd_a_e == FSW'(k)) w_src_a = fwd_vals[k*WIDTH-1 -: WIDTH];
      if (fwd_b_e == FSW'(k)) w_src_b = fwd_vals[k*WIDTH-1 -: WIDTH];
    end
  end

  assign w_op_b       = alu_src_e ? sign_imm_e : w_src_b;
  assign write_data_e = w_src_b;
  assign write_reg_e  = reg_dst_e ? rd_e : rt_e;
  assign rs_hazard    = rs_e;
  assign rt_hazard    = rt_e;

  always_comb begin
    alu_out_e = '0;
    case (w_op)
      OpAdd:   alu_out_e = w_src_a + w_op_b;
      OpSub:   alu_out_e = w_src_a - w_op_b;
      OpAnd:   alu_out_e = w_src_a & w_op_b;
      OpOr:    alu_out_e = w_src_a | w_op_b;
      OpXor:   alu_out_e = w_src_a ^ w_op_b;
      OpNor:   alu_out_e = ~(w_src_a | w_op_b);
      OpSlt:   alu_out_e[0] = $signed(w_src_a) < $signed(w_op_b);
      OpSltu:  alu_out_e[0] = w_src_a < w_op_b;
      OpMfhi:  alu_out_e = w_hi;
      OpMflo:  alu_out_e = w_lo;
      default: alu_out_e = '0;
    endcase
  end

  exec_md_unit #(
    .WIDTH (WIDTH)
  ) u_md_unit (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (valid_e),
    .i_flush (flush_e),
    .i_op    (w_op),
    .i_a     (w_src_a),
    .i_b     (w_src_b),
    .o_stall (md_stall),
    .o_done  (md_done),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

endmodule

// File: tb/tb_exec_stage_md.sv
// Randomized self-checking bench for exec_stage_md against an arithmetic reference model.
module tb_exec_stage_md;
  import exec_pkg::*;

  localparam int W = 32;
`ifdef EXEC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid_e, flush_e, alu_src_e, reg_dst_e, md_stall, md_done;
  logic [3:0]  alu_ctrl_e;
  logic [31:0] reg1, reg2, sign_imm_e, alu_out_e, write_data_e;
  logic [4:0]  rs_e, rt_e, rd_e, write_reg_e, rs_hazard, rt_hazard;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [63:0] fwd_vals;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  exec_stage_md #(
    .WIDTH    (32),
    .REG_AW   (5),
    .FWD_SRCS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_e      (valid_e),
    .flush_e      (flush_e),
    .alu_ctrl_e   (alu_ctrl_e),
    .alu_src_e    (alu_src_e),
    .reg_dst_e    (reg_dst_e),
    .reg1         (reg1),
    .reg2         (reg2),
    .sign_imm_e   (sign_imm_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .rd_e         (rd_e),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .fwd_vals     (fwd_vals),
    .alu_out_e    (alu_out_e),
    .write_data_e (write_data_e),
    .write_reg_e  (write_reg_e),
    .rs_hazard    (rs_hazard),
    .rt_hazard    (rt_hazard),
    .md_stall     (md_stall),
    .md_done      (md_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return fwd_vals[31:0];
    if (sel == 2'd2) return fwd_vals[63:32];
    return r;
  endfunction

  function automatic logic [31:0] alu_model(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpNor:   return ~(a | b);
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpSltu:  return (a < b) ? 32'd1 : 32'd0;
      OpMfhi:  return m_hi;
      OpMflo:  return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void md_model(input alu_op_e op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OpMult:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      OpMultu: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OpDiv: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin
          p = 64'(sa / sb); m_lo = p[31:0];
          p = 64'(sa % sb); m_hi = p[31:0];
        end
      end
      OpDivu: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic read_hilo(input string tag);
    @(posedge clk); #1;
    valid_e = 1'b1; flush_e = 1'b0; fwd_a_e = 2'd0; fwd_b_e = 2'd0;
    alu_ctrl_e = OpMfhi; #1;
    check({tag, "_mfhi"}, alu_out_e, m_hi);
    check({tag, "_mf_stall"}, md_stall, 0);
    alu_ctrl_e = OpMflo; #1;
    check({tag, "_mflo"}, alu_out_e, m_lo);
    valid_e = 1'b0;
  endtask

  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    valid_e = 1'b1; flush_e = 1'b0; alu_ctrl_e = op; reg1 = a; reg2 = b;
    fwd_a_e = 2'd0; fwd_b_e = 2'd0; alu_src_e = 1'b0;
  endtask

  // flush_at = 0 means no flush; otherwise flush_e is raised in that BUSY cycle.
  task automatic run_md(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int flush_at);
    bit accepted, flushed;
    accepted = (op == OpMult) || (op == OpMultu) || DivEn;
    @(posedge clk); #1;
    issue(op, a, b); #1;
    check({tag, "_issue_stall"}, md_stall, accepted);
    check({tag, "_issue_out"}, alu_out_e, 0);
    check({tag, "_issue_done"}, md_done, 0);
    if (!accepted) begin
      @(posedge clk); #1;
      valid_e = 1'b0; #1;
      check({tag, "_noop_done"}, md_done, 0);
      check({tag, "_noop_stall"}, md_stall, 0);
    end else begin
      for (int c = 1; c <= W + 1; c++) begin
        @(posedge clk); #1;
        if (c == flush_at) flush_e = 1'b1;
        if (flush_at > 0 && c == flush_at + 1) begin flush_e = 1'b0; valid_e = 1'b0; end
        #1;
        flushed = (flush_at > 0) && (c > flush_at);
        check({tag, "_stall"}, md_stall, !flushed && c <= W);
        check({tag, "_done"}, md_done, !flushed && c == W && c != flush_at);
      end
      if (flush_at == 0) md_model(op, a, b);
    end
    read_hilo(tag);
  endtask

  task automatic run_reset_mid(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    issue(op, a, b); #1;
    check("rst_issue_stall", md_stall, 1);
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("rst_mid_stall", md_stall, 0);
    check("rst_mid_done", md_done, 0);
    valid_e = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    m_hi = '0; m_lo = '0;
    check("rst_after_stall", md_stall, 0);
    read_hilo("rst");
  endtask

  alu_op_e alu_ops[10] = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu,
                           OpMfhi, OpMflo};
  alu_op_e md_ops[4]   = '{OpMult, OpMultu, OpDiv, OpDivu};

  initial begin
    alu_op_e     op;
    logic [31:0] a, b, bop;
    rst_n = 1'b0; valid_e = 1'b1; flush_e = 1'b0; alu_ctrl_e = OpMult;
    alu_src_e = 1'b0; reg_dst_e = 1'b0; reg1 = 32'd9; reg2 = 32'd9; sign_imm_e = '0;
    rs_e = '0; rt_e = '0; rd_e = '0; fwd_a_e = '0; fwd_b_e = '0; fwd_vals = '0;
    #1;
    check("reset_stall", md_stall, 0);
    check("reset_done", md_done, 0);
    repeat (2) @(posedge clk);
    #1; valid_e = 1'b0; rst_n = 1'b1;
    read_hilo("reset");

    // Forwarding from source 2, then an out-of-range select falls back to reg1.
    @(posedge clk); #1;
    valid_e = 1'b1; alu_ctrl_e = OpAdd; reg1 = 32'h100; reg2 = 32'd3;
    fwd_vals = {32'h10, 32'hABCD}; fwd_a_e = 2'd2; fwd_b_e = 2'd0; #1;
    check("fwd_src2_add", alu_out_e, 32'h13);
    fwd_a_e = 2'd3; #1;
    check("fwd_sel3_reg", alu_out_e, 32'h103);

    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      op = alu_ops[$urandom_range(0, 9)];
      valid_e = 1'b1; flush_e = 1'b0; alu_ctrl_e = op;
      reg1 = $urandom; reg2 = ($urandom_range(0, 3) == 0) ? reg1 : $urandom;
      if ($urandom_range(0, 4) == 0) reg1 = 32'h8000_0000;
      sign_imm_e = $urandom; fwd_vals = {$urandom, $urandom};
      fwd_a_e = 2'($urandom_range(0, 3)); fwd_b_e = 2'($urandom_range(0, 3));
      alu_src_e = 1'($urandom); reg_dst_e = 1'($urandom);
      rs_e = 5'($urandom); rt_e = 5'($urandom); rd_e = 5'($urandom);
      #1;
      a   = fwd_pick(fwd_a_e, reg1);
      bop = fwd_pick(fwd_b_e, reg2);
      b   = alu_src_e ? sign_imm_e : bop;
      check("alu_out", alu_out_e, alu_model(op, a, b));
      check("write_data", write_data_e, bop);
      check("write_reg", write_reg_e, reg_dst_e ? rd_e : rt_e);
      check("hazard_pass", {rs_hazard, rt_hazard}, {rs_e, rt_e});
      check("alu_stall", md_stall, 0);
    end
    valid_e = 1'b0; fwd_vals = '0;

    run_md("mult_neg", OpMult, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_md("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 0);
    run_md("divu_zero", OpDivu, 32'd7, 32'd0, 0);
    run_md("div_zero_s", OpDiv, 32'hFFFF_FF00, 32'd0, 0);
    run_md("multu_30", OpMultu, 32'd5, 32'd6, 0);
    run_md("mult_flush", OpMult, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_md("multu_flush_last", OpMultu, 32'hDEAD_BEEF, 32'h0BAD_F00D, W);

    for (int i = 0; i < 8; i++) begin
      op = md_ops[$urandom_range(0, 3)];
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      run_md("md_rand", op, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0);
    end

    run_reset_mid(DivEn ? OpDiv : OpMult, 32'd100, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
